// File: rtl/uart_ctrl.sv
// uart_ctrl: UART transmitter and receiver sharing one clock, with a small RX FIFO.
//
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even parity, stop bit(s) (1).
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9)
//   CLKS_PER_BIT clock cycles per bit period (>= 8)
//   STOP_BITS    stop bits sent by TX (1 or 2); RX always checks exactly one
//   FIFO_DEPTH   RX FIFO entries (power of two, >= 2)
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous reset, active LOW
//   i_rxd            serial receive line (asynchronous, idle high)
//   o_txd            serial transmit line (idle high)
//   i_tx_data        word to transmit
//   i_tx_valid       i_tx_data valid
//   o_tx_ready       transmitter idle and able to accept a word
//   o_rx_data        head-of-FIFO received word (0 when FIFO empty)
//   o_rx_valid       RX FIFO not empty
//   i_rx_ready       consumer pops the head word when o_rx_valid is high
//   o_rx_frame_err   one-cycle pulse, stop bit sampled low
//   o_rx_overrun     one-cycle pulse, good word dropped because FIFO full
//   o_tx_busy        TX frame in progress
//   o_rx_busy        RX frame in progress
//   o_rx_parity_err  one-cycle pulse, parity mismatch (UART_CTRL_PARITY_EN only)
//
// Configuration macro:
//   UART_CTRL_PARITY_EN  when defined, an even parity bit follows the data on
//                        both TX and RX, and o_rx_parity_err is present.

module uart_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rxd,
    output logic                 o_txd,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_overrun,
    output logic                 o_tx_busy,
    output logic                 o_rx_busy
`ifdef UART_CTRL_PARITY_EN
    ,
    output logic                 o_rx_parity_err
`endif
);

    localparam int TX_CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int RX_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [TX_CNT_W-1:0] TX_BIT_LAST  = TX_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TX_CNT_W-1:0] TX_STOP_LAST = TX_CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [TX_CNT_W-1:0] TX_CNT_ONE   = TX_CNT_W'(1);
    localparam logic [RX_CNT_W-1:0] RX_BIT_LAST  = RX_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [RX_CNT_W-1:0] RX_HALF_LAST = RX_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RX_CNT_W-1:0] RX_CNT_ONE   = RX_CNT_W'(1);
    localparam logic [BIT_W-1:0]    BIT_LAST     = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]    BIT_ONE      = BIT_W'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE      = PTR_W'(1);
    localparam logic [PTR_W:0]      CNT_ONE      = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]      FIFO_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_CTRL_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
`endif

    // ---------------- Transmitter ----------------
    txState_t              r_txState;
    txState_t              w_txStateNext;
    logic [TX_CNT_W-1:0]   r_txCnt;
    logic [BIT_W-1:0]      r_txBitIdx;
    logic [DATA_BITS-1:0]  r_txShift;
    logic                  w_txBitDone;
`ifdef UART_CTRL_PARITY_EN
    logic                  r_txParity;
`endif

    assign w_txBitDone = (r_txCnt == TX_BIT_LAST);

    // TX state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_txState <= TX_IDLE;
        end else begin
            r_txState <= w_txStateNext;
        end
    end

    // TX next state and outputs; txd is decoded from state so reset forces it high at once.
    always_comb begin
        w_txStateNext = r_txState;
        o_tx_ready    = 1'b0;
        o_tx_busy     = 1'b1;
        o_txd         = 1'b1;
        case (r_txState)
            TX_IDLE: begin
                o_tx_ready = 1'b1;
                o_tx_busy  = 1'b0;
                if (i_tx_valid) begin
                    w_txStateNext = TX_START;
                end
            end
            TX_START: begin
                o_txd = 1'b0;
                if (w_txBitDone) begin
                    w_txStateNext = TX_DATA;
                end
            end
            TX_DATA: begin
                o_txd = r_txShift[0];
                if (w_txBitDone && (r_txBitIdx == BIT_LAST)) begin
`ifdef UART_CTRL_PARITY_EN
                    w_txStateNext = TX_PARITY;
`else
                    w_txStateNext = TX_STOP;
`endif
                end
            end
`ifdef UART_CTRL_PARITY_EN
            TX_PARITY: begin
                o_txd = r_txParity;
                if (w_txBitDone) begin
                    w_txStateNext = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                o_txd = 1'b1;
                if (r_txCnt == TX_STOP_LAST) begin
                    w_txStateNext = TX_IDLE;
                end
            end
            default: begin
                w_txStateNext = TX_IDLE;
            end
        endcase
    end

    // TX datapath: bit timer restarts on every state change, shift register drains LSB first.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_txCnt    <= '0;
            r_txBitIdx <= '0;
            r_txShift  <= '0;
`ifdef UART_CTRL_PARITY_EN
            r_txParity <= 1'b0;
`endif
        end else begin
            if ((r_txState == TX_IDLE) || (w_txStateNext != r_txState)) begin
                r_txCnt <= '0;
            end else begin
                r_txCnt <= r_txCnt + TX_CNT_ONE;
            end
            if (r_txState == TX_IDLE) begin
                r_txBitIdx <= '0;
                if (i_tx_valid) begin
                    r_txShift <= i_tx_data;
`ifdef UART_CTRL_PARITY_EN
                    r_txParity <= ^i_tx_data;
`endif
                end
            end else if ((r_txState == TX_DATA) && w_txBitDone) begin
                r_txBitIdx <= r_txBitIdx + BIT_ONE;
                r_txShift  <= r_txShift >> 1;
            end
        end
    end

    // ---------------- Receiver ----------------
    rxState_t              r_rxState;
    rxState_t              w_rxStateNext;
    logic                  r_rxSync1;
    logic                  r_rxSync2;
    logic                  r_rxPrev;
    logic [RX_CNT_W-1:0]   r_rxCnt;
    logic [BIT_W-1:0]      r_rxBitIdx;
    logic [DATA_BITS-1:0]  r_rxShift;
    logic                  w_rxFall;
    logic                  w_rxBitDone;
    logic                  w_rxStopSample;
    logic                  w_rxParityOk;
    logic                  w_rxWordGood;
    logic                  r_frameErr;
    logic                  r_overrun;
`ifdef UART_CTRL_PARITY_EN
    logic                  r_rxParityBit;
    logic                  r_parityErr;
`endif

    // Synchroniser and edge history reset low: a line already low after reset
    // must first be seen high before a falling edge can start a frame.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rxSync1 <= 1'b0;
            r_rxSync2 <= 1'b0;
            r_rxPrev  <= 1'b0;
        end else begin
            r_rxSync1 <= i_rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_rxFall       = r_rxPrev && !r_rxSync2;
    assign w_rxBitDone    = (r_rxCnt == RX_BIT_LAST);
    assign w_rxStopSample = (r_rxState == RX_STOP) && w_rxBitDone;
`ifdef UART_CTRL_PARITY_EN
    assign w_rxParityOk   = ((^r_rxShift) == r_rxParityBit);
`else
    assign w_rxParityOk   = 1'b1;
`endif
    assign w_rxWordGood   = w_rxStopSample && r_rxSync2 && w_rxParityOk;

    // RX state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxStateNext;
        end
    end

    // RX next state; START samples at half a bit to reject glitches, later bits at bit centres.
    always_comb begin
        w_rxStateNext = r_rxState;
        o_rx_busy     = 1'b1;
        case (r_rxState)
            RX_IDLE: begin
                o_rx_busy = 1'b0;
                if (w_rxFall) begin
                    w_rxStateNext = RX_START;
                end
            end
            RX_START: begin
                if (r_rxCnt == RX_HALF_LAST) begin
                    w_rxStateNext = r_rxSync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rxBitDone && (r_rxBitIdx == BIT_LAST)) begin
`ifdef UART_CTRL_PARITY_EN
                    w_rxStateNext = RX_PARITY;
`else
                    w_rxStateNext = RX_STOP;
`endif
                end
            end
`ifdef UART_CTRL_PARITY_EN
            RX_PARITY: begin
                if (w_rxBitDone) begin
                    w_rxStateNext = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (w_rxBitDone) begin
                    w_rxStateNext = RX_IDLE;
                end
            end
            default: begin
                w_rxStateNext = RX_IDLE;
            end
        endcase
    end

    // RX datapath and error pulses.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rxCnt    <= '0;
            r_rxBitIdx <= '0;
            r_rxShift  <= '0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_CTRL_PARITY_EN
            r_rxParityBit <= 1'b0;
            r_parityErr   <= 1'b0;
`endif
        end else begin
            if ((r_rxState == RX_IDLE) || (w_rxStateNext != r_rxState)) begin
                r_rxCnt <= '0;
            end else begin
                r_rxCnt <= r_rxCnt + RX_CNT_ONE;
            end
            if (r_rxState == RX_IDLE) begin
                r_rxBitIdx <= '0;
            end else if ((r_rxState == RX_DATA) && w_rxBitDone) begin
                r_rxBitIdx <= r_rxBitIdx + BIT_ONE;
                r_rxShift  <= {r_rxSync2, r_rxShift[DATA_BITS-1:1]};
            end
`ifdef UART_CTRL_PARITY_EN
            if ((r_rxState == RX_PARITY) && w_rxBitDone) begin
                r_rxParityBit <= r_rxSync2;
            end
            r_parityErr <= w_rxStopSample && r_rxSync2 && !w_rxParityOk;
`endif
            r_frameErr <= w_rxStopSample && !r_rxSync2;
            r_overrun  <= w_rxWordGood && w_fifoFull && !w_pop;
        end
    end

    assign o_rx_frame_err = r_frameErr;
    assign o_rx_overrun   = r_overrun;
`ifdef UART_CTRL_PARITY_EN
    assign o_rx_parity_err = r_parityErr;
`endif

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W:0]       r_fifoCount;
    logic                 w_fifoFull;
    logic                 w_pop;
    logic                 w_push;

    assign w_fifoFull = (r_fifoCount == FIFO_FULL);
    assign o_rx_valid = (r_fifoCount != '0);
    assign w_pop      = o_rx_valid && i_rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_rxWordGood && (!w_fifoFull || w_pop);
    assign o_rx_data  = o_rx_valid ? r_fifoMem[r_rdPtr] : '0;

    // Storage needs no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= r_rxShift;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_fifoCount <= r_fifoCount + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_fifoCount <= r_fifoCount - CNT_ONE;
            end
        end
    end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 434, clk cycles per bit period, minimum 8.
REQ-003 Parameter STOP_BITS, default 1, TX stop bits, legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, RX FIFO entries, power of two, minimum 2.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rxd  input  1  serial receive line, asynchronous to clk, idle high.
REQ-008 txd  output  1  serial transmit line, idle high.
REQ-009 tx_data  input  DATA_BITS  word to transmit.
REQ-010 tx_valid  input  1  tx_data valid.
REQ-011 tx_ready  output  1  transmitter can accept a word.
REQ-012 rx_data  output  DATA_BITS  head-of-FIFO received word.
REQ-013 rx_valid  output  1  RX FIFO not empty.
REQ-014 rx_ready  input  1  consumer pops head word.
REQ-015 rx_frame_err  output  1  one-cycle pulse, bad stop bit.
REQ-016 rx_overrun  output  1  one-cycle pulse, word dropped on full FIFO.
REQ-017 tx_busy / rx_busy  output  1 each  frame in progress on TX / RX.

Function
REQ-018 Frame format SHALL be: start bit 0, DATA_BITS data bits with bit 0 first, optional parity, stop bit(s) 1.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-020 A word SHALL be accepted on the cycle tx_valid and tx_ready are both 1; txd drives 0 from the next cycle.
REQ-021 Each TX bit SHALL be held exactly CLKS_PER_BIT cycles; STOP lasts STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
REQ-022 Back-to-back: tx_ready SHALL rise the cycle after STOP ends, giving no idle gap when tx_valid is held high.
REQ-023 rxd SHALL pass a two-flop synchroniser before any use.
REQ-024 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE leaves on a synchronised 1-to-0 transition.
REQ-025 START SHALL re-sample at CLKS_PER_BIT/2 cycles; if high, false start, return to IDLE with no output.
REQ-026 Data, parity and stop bits SHALL be sampled at bit centres (CLKS_PER_BIT after the previous sample).
REQ-027 RX SHALL check one stop bit regardless of STOP_BITS and return to IDLE right after the stop sample.
REQ-028 Stop sample 0: rx_frame_err pulses one cycle, word discarded, not pushed.
REQ-029 Good word with FIFO full and no pop that cycle: word dropped, rx_overrun pulses one cycle, FIFO unchanged.
REQ-030 Simultaneous push and pop on a full FIFO SHALL succeed with no overrun; on an empty FIFO the push SHALL be visible the next cycle.
REQ-031 Pop on rx_valid and rx_ready both 1; rx_data SHALL hold stable while rx_valid=1 and no pop.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-033 tx_busy=1 in any TX state but IDLE; rx_busy=1 in any RX state but IDLE.

Reset
REQ-034 reset=0 SHALL immediately force txd=1, tx_ready=1, tx_busy=0, rx_busy=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_data=0, FIFO empty, both FSMs IDLE.
REQ-035 Reset mid-frame SHALL abort the frame; no partial word enters the FIFO.
REQ-036 After reset release, a line held low SHALL NOT start reception until a 1-to-0 transition.

Configuration
REQ-037 Macro UART_CTRL_PARITY_EN defined: even parity bit after data on TX and RX; port rx_parity_err (output, 1) pulses one cycle on mismatch and the word is discarded.
REQ-038 Macro undefined: no PARITY state, no parity bit, no rx_parity_err port.

Verification
REQ-039 CLKS_PER_BIT=8, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 8 cycles; tx_ready low 80 cycles.
REQ-040 Loop txd to rxd, send 0x00, 0xFF, 0x3C, rx_ready=1 -> rx_valid pulses with same data in order, no errors.
REQ-041 Drive 2-cycle low glitch on rxd, CLKS_PER_BIT=8 -> false start, rx_valid stays 0, rx_busy returns 0.
REQ-042 Frame 0x55 with stop bit 0 -> rx_frame_err one-cycle pulse, FIFO count unchanged.
REQ-043 FIFO_DEPTH=4, rx_ready=0, receive 5 words -> 4 stored, rx_overrun pulse on 5th; pop all gives words 1..4.
REQ-044 Assert reset mid-DATA on TX and RX -> txd=1 at once, rx_valid=0, next frame received correctly.
